// File: rtl/mac_pkg.sv
// Shared widths, pipeline-depth limits, sideband type and saturation constants
// for the pipelined multiply-accumulate block.
package mac_pkg;

  localparam int DEF_A_W   = 32;
  localparam int DEF_B_W   = 32;
  localparam int DEF_ACC_W = 80;
  localparam int DEF_PIPE  = 3;
  localparam int PIPE_MIN  = 1;
  localparam int PIPE_MAX  = 4;

  // Widest accumulator the saturation helpers can describe.
  localparam int SAT_W_MAX = 256;

  typedef struct packed {
    logic signed_mode;
    logic acc_mode;
    logic clear_acc;
  } side_t;

  function automatic logic [SAT_W_MAX-1:0] sat_smax(input int w);
    return (SAT_W_MAX'(1) << (w - 1)) - SAT_W_MAX'(1);
  endfunction

  function automatic logic [SAT_W_MAX-1:0] sat_smin(input int w);
    return SAT_W_MAX'(1) << (w - 1);
  endfunction

  function automatic logic [SAT_W_MAX-1:0] sat_umax(input int w);
    if (w >= SAT_W_MAX) return '1;
    return (SAT_W_MAX'(1) << w) - SAT_W_MAX'(1);
  endfunction

endpackage

// File: rtl/pipelined_mac_if.sv
// Sample-in / result-out bus of the pipelined MAC.
// Handshake: a beat moves when valid && ready on the same rising edge; a
// producer holds valid and payload steady until ready is seen, and ready never
// depends on valid.
interface pipelined_mac_if
  import mac_pkg::*;
#(
  parameter int A_W   = DEF_A_W,
  parameter int B_W   = DEF_B_W,
  parameter int ACC_W = DEF_ACC_W
);

  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   a;
  logic [B_W-1:0]   b;
  logic             signed_mode;
  logic             acc_mode;
  logic             clear_acc;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] p;
  logic             overflow;

  modport master (
    output in_valid, a, b, signed_mode, acc_mode, clear_acc, out_ready,
    input  in_ready, out_valid, p, overflow
  );

  modport slave (
    input  in_valid, a, b, signed_mode, acc_mode, clear_acc, out_ready,
    output in_ready, out_valid, p, overflow
  );

endinterface

// File: rtl/mac_mult_pipe.sv
// PIPE-stage product pipeline: exact A_W+B_W-bit product with per-sample
// sideband, advancing only when the consumer is not stalled.
module mac_mult_pipe
  import mac_pkg::*;
#(
  parameter int A_W  = DEF_A_W,
  parameter int B_W  = DEF_B_W,
  parameter int PIPE = DEF_PIPE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               advance,
  input  logic               in_valid,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  input  side_t              in_side,
  output logic               out_valid,
  output logic [A_W+B_W-1:0] out_prod,
  output side_t              out_side
);

  localparam int PW = A_W + B_W;

  logic [PW-1:0] ax;
  logic [PW-1:0] bx;
  logic [PW-1:0] prod;

  logic [PIPE-1:0] valid_q;
  logic [PW-1:0]   prod_q [PIPE];
  side_t           side_q [PIPE];

  // Extending both operands to the full product width makes the truncated
  // product exact for signed and unsigned alike.
  always_comb begin
    ax   = in_side.signed_mode ? PW'($signed(a)) : PW'(a);
    bx   = in_side.signed_mode ? PW'($signed(b)) : PW'(b);
    prod = ax * bx;
  end

  // The first register captures the product; later stages are pure delay and
  // are left for the synthesis tool to retime into the multiplier.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < PIPE; i++) begin
        prod_q[i] <= '0;
        side_q[i] <= '0;
      end
    end else if (advance) begin
      valid_q[0] <= in_valid;
      prod_q[0]  <= prod;
      side_q[0]  <= in_side;
      for (int i = 1; i < PIPE; i++) begin
        valid_q[i] <= valid_q[i-1];
        prod_q[i]  <= prod_q[i-1];
        side_q[i]  <= side_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[PIPE-1];
  assign out_prod  = prod_q[PIPE-1];
  assign out_side  = side_q[PIPE-1];

endmodule

// File: rtl/pipelined_mac.sv
// Pipelined multiply-accumulate with saturation: product pipeline followed by a
// single accumulate/saturate/output stage under valid/ready flow control.
module pipelined_mac
  import mac_pkg::*;
#(
  parameter int A_W   = DEF_A_W,
  parameter int B_W   = DEF_B_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int PIPE  = DEF_PIPE
) (
  input  logic           clk,
  input  logic           reset,
  pipelined_mac_if.slave bus
);

  localparam int PW = A_W + B_W;

  localparam logic [ACC_W-1:0] SMAX = ACC_W'(sat_smax(ACC_W));
  localparam logic [ACC_W-1:0] SMIN = ACC_W'(sat_smin(ACC_W));
  localparam logic [ACC_W-1:0] UMAX = ACC_W'(sat_umax(ACC_W));

  logic stall;
  logic advance;

  logic          m_valid;
  logic [PW-1:0] m_prod;
  side_t         m_side;
  side_t         in_side;

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] p_q;
  logic             out_valid_q;
  logic             overflow_q;

  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   sum_s;
  logic [ACC_W:0]   sum_u;
  logic [ACC_W-1:0] acc_next;
  logic             sat;

  assign stall   = out_valid_q && !bus.out_ready;
  assign advance = !stall;

  assign in_side.signed_mode = bus.signed_mode;
  assign in_side.acc_mode    = bus.acc_mode;
  assign in_side.clear_acc   = bus.clear_acc;

  mac_mult_pipe #(
    .A_W  (A_W),
    .B_W  (B_W),
    .PIPE (PIPE)
  ) u_mult (
    .clk       (clk),
    .reset     (reset),
    .advance   (advance),
    .in_valid  (bus.in_valid),
    .a         (bus.a),
    .b         (bus.b),
    .in_side   (in_side),
    .out_valid (m_valid),
    .out_prod  (m_prod),
    .out_side  (m_side)
  );

  // One guard bit above the accumulator width exposes overflow: for signed
  // sums the two top bits disagree, for unsigned sums the carry is set.
  always_comb begin
    ext      = m_side.signed_mode ? ACC_W'($signed(m_prod)) : ACC_W'(m_prod);
    base     = m_side.clear_acc ? '0 : acc_q;
    sum_s    = {base[ACC_W-1], base} + {ext[ACC_W-1], ext};
    sum_u    = {1'b0, base} + {1'b0, ext};
    sat      = 1'b0;
    acc_next = '0;
    if (m_side.signed_mode) begin
      sat      = sum_s[ACC_W] != sum_s[ACC_W-1];
      acc_next = sat ? (sum_s[ACC_W] ? SMIN : SMAX) : sum_s[ACC_W-1:0];
    end else begin
      sat      = sum_u[ACC_W];
      acc_next = sat ? UMAX : sum_u[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (advance) begin
      out_valid_q <= m_valid;
      if (m_valid) begin
        if (m_side.acc_mode) begin
          acc_q <= acc_next;
          p_q   <= acc_next;
          if (sat) begin
            overflow_q <= 1'b1;
          end else if (m_side.clear_acc) begin
            overflow_q <= 1'b0;
          end
        end else begin
          p_q <= ext;
        end
      end
    end
  end

  assign bus.in_ready  = !stall;
  assign bus.out_valid = out_valid_q;
  assign bus.p         = p_q;
  assign bus.overflow  = overflow_q;

endmodule
